// File: rtl/sram_arbiter_if.sv
// Memory-side bus of the SRAM arbiter: one request/ack port with byte enables.
// The master modport is the arbiter and the slave modport is the memory.
interface sram_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  mem_req;
  logic [DATA_W/8-1:0]   mem_wen;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W-1:0]     mem_rdata;
  logic                  mem_ack;

  modport master (
    output mem_req, mem_wen, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_wen, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/sram_arbiter.sv
// Shares one variable-latency memory port between instruction fetch and data access.
// Data is served first so a store lands before a fetch issued in the same cycle.
module sram_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inst_req,
  input  logic [ADDR_W-1:0]    inst_addr,
  output logic [DATA_W-1:0]    inst_rdata,
  input  logic                 data_req,
  input  logic [DATA_W/8-1:0]  data_wen,
  input  logic [ADDR_W-1:0]    data_addr,
  input  logic [DATA_W-1:0]    data_wdata,
  output logic [DATA_W-1:0]    data_rdata,
  output logic                 stallreq_for_mem,
  sram_arbiter_if.master       mem
);
  localparam int BE_W = DATA_W / 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_INST = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                inst_pend_q, inst_pend_d;
  logic [ADDR_W-1:0]   inst_addr_q, inst_addr_d;
  logic                mem_req_q, mem_req_d;
  logic [BE_W-1:0]     mem_wen_q, mem_wen_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0]   inst_rdata_q, inst_rdata_d;
  logic [DATA_W-1:0]   data_rdata_q, data_rdata_d;
  logic                stall_s;

  // Next-state, memory command and read-data capture logic.
  always_comb begin
    state_d      = state_q;
    inst_pend_d  = inst_pend_q;
    inst_addr_d  = inst_addr_q;
    mem_req_d    = mem_req_q;
    mem_wen_d    = mem_wen_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    inst_rdata_d = inst_rdata_q;
    data_rdata_d = data_rdata_q;
    stall_s      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        stall_s = inst_req | data_req;
        if (data_req) begin
          state_d     = ST_DATA;
          mem_req_d   = 1'b1;
          mem_wen_d   = data_wen;
          mem_addr_d  = data_addr;
          mem_wdata_d = data_wdata;
          inst_pend_d = inst_req;
          inst_addr_d = inst_addr;
        end else if (inst_req) begin
          state_d     = ST_INST;
          mem_req_d   = 1'b1;
          mem_wen_d   = {BE_W{1'b0}};
          mem_addr_d  = inst_addr;
          mem_wdata_d = {DATA_W{1'b0}};
          inst_pend_d = 1'b1;
          inst_addr_d = inst_addr;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DATA: begin
        stall_s = 1'b1;
        if (mem.mem_ack) begin
          // A store (any byte enable set) must leave data_rdata untouched.
          if (mem_wen_q == {BE_W{1'b0}}) begin
            data_rdata_d = mem.mem_rdata;
          end else begin
            data_rdata_d = data_rdata_q;
          end
          if (inst_pend_q) begin
            state_d     = ST_INST;
            mem_req_d   = 1'b1;
            mem_wen_d   = {BE_W{1'b0}};
            mem_addr_d  = inst_addr_q;
            mem_wdata_d = {DATA_W{1'b0}};
          end else begin
            state_d     = ST_DONE;
            mem_req_d   = 1'b0;
            mem_wen_d   = {BE_W{1'b0}};
            mem_addr_d  = {ADDR_W{1'b0}};
            mem_wdata_d = {DATA_W{1'b0}};
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_INST: begin
        stall_s = 1'b1;
        if (mem.mem_ack) begin
          state_d      = ST_DONE;
          inst_rdata_d = mem.mem_rdata;
          inst_pend_d  = 1'b0;
          mem_req_d    = 1'b0;
          mem_wen_d    = {BE_W{1'b0}};
          mem_addr_d   = {ADDR_W{1'b0}};
          mem_wdata_d  = {DATA_W{1'b0}};
        end else begin
          state_d = ST_INST;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d     = ST_IDLE;
        inst_pend_d = 1'b0;
        mem_req_d   = 1'b0;
        mem_wen_d   = {BE_W{1'b0}};
        mem_addr_d  = {ADDR_W{1'b0}};
        mem_wdata_d = {DATA_W{1'b0}};
      end
    endcase
  end

  // State and output registers; reset drops any in-flight request at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      inst_pend_q  <= 1'b0;
      inst_addr_q  <= {ADDR_W{1'b0}};
      mem_req_q    <= 1'b0;
      mem_wen_q    <= {BE_W{1'b0}};
      mem_addr_q   <= {ADDR_W{1'b0}};
      mem_wdata_q  <= {DATA_W{1'b0}};
      inst_rdata_q <= {DATA_W{1'b0}};
      data_rdata_q <= {DATA_W{1'b0}};
    end else begin
      state_q      <= state_d;
      inst_pend_q  <= inst_pend_d;
      inst_addr_q  <= inst_addr_d;
      mem_req_q    <= mem_req_d;
      mem_wen_q    <= mem_wen_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
    end
  end

  assign mem.mem_req       = mem_req_q;
  assign mem.mem_wen       = mem_wen_q;
  assign mem.mem_addr      = mem_addr_q;
  assign mem.mem_wdata     = mem_wdata_q;
  assign inst_rdata        = inst_rdata_q;
  assign data_rdata        = data_rdata_q;
  assign stallreq_for_mem  = stall_s;
endmodule
